// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// =============================================================================
// fifo_uart_tx
// -----------------------------------------------------------------------------
// UART transmitter that drains the read side of a 16x8 byte FIFO.
// Each byte is fetched with a single-cycle read pulse. It is captured from the
// FIFO's registered read data and sent LSB first on one serial line.
//
// Default build: 8N1 frame (start, 8 data, stop), 10*CLKS_PER_BIT cycles.
// Optional build macro FIFO_UART_TX_PARITY_EN: 8E1 frame with an even-parity
// bit between data bit 7 and the stop bit, 11*CLKS_PER_BIT cycles.
//
// Parameters:
//   CLKS_PER_BIT      clock cycles per serial bit, legal range 2..65535
//
// Ports:
//   clock_in          system clock, rising edge
//   n_reset_in        asynchronous active-low reset
//   enable_in         allows a new frame to start (sampled only in IDLE)
//   fifo_readable_in  FIFO holds at least one byte
//   fifo_rdata_in     FIFO registered read data, valid the cycle after a
//                     read pulse is sampled
//   fifo_read_out     one-cycle read strobe to the FIFO
//   tx_out            serial line, idles high
//   busy_out          high whenever the FSM is not in IDLE
//
// Frame timing from IDLE with a byte available:
//   edge 1: IDLE  -> READ  (read strobe asserted)
//   edge 2: READ  -> LOAD  (FIFO samples strobe, data appears)
//   edge 3: LOAD  -> START (byte captured, start bit driven)
// Back-to-back frames therefore have a fixed 3-cycle idle-high gap after the
// stop bit.
// =============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock_in,
    input  logic       n_reset_in,
    input  logic       enable_in,
    input  logic       fifo_readable_in,
    input  logic [7:0] fifo_rdata_in,
    output logic       fifo_read_out,
    output logic       tx_out,
    output logic       busy_out
);

    // Counter is wide enough to hold CLKS_PER_BIT-1 and never exceeds it.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        STOP   = 3'd5,
        PARITY = 3'd6
`else
        STOP   = 3'd5
`endif
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             read_q;
    logic             tx_q;
    logic             busy_q;
    logic             bit_done;
`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is latched with the byte because the shifter destroys it.
    logic             par_q;
`endif

    // Final cycle of the current serial bit; the counter wraps to 0 there.
    assign bit_done = (cnt_q == CNT_LAST);
    assign cnt_d    = bit_done ? '0 : (cnt_q + CNT_W'(1));

    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            read_q    <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (enable_in && fifo_readable_in) begin
                        state_q <= READ;
                        read_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                // Strobe is high for exactly this one cycle.
                READ: begin
                    read_q  <= 1'b0;
                    state_q <= LOAD;
                end

                // FIFO data is valid now; capture it once and drive the start bit.
                LOAD: begin
                    shift_q <= fifo_rdata_in;
`ifdef FIFO_UART_TX_PARITY_EN
                    par_q   <= ^fifo_rdata_in;
`endif
                    tx_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= START;
                end

                START: begin
                    cnt_q <= cnt_d;
                    if (bit_done) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= 3'd0;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_done) begin
                        if (bit_idx_q != 3'd7) begin
                            // shift_q[1] becomes the new LSB on this edge.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end else begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_done) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
`endif

                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    read_q  <= 1'b0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read_out = read_q;
    assign tx_out        = tx_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       n_reset;
    logic       enable;
    logic       wr_en;
    logic [7:0] wdata;
    logic       readable;
    logic [7:0] rdata = 8'h00;
    logic       rd;
    logic       tx;
    logic       busy;

    // Behavioural 16x8 FIFO with registered read data.
    logic [7:0] mem [0:15];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    int         fcnt = 0;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int rd_long = 0;
    logic rd_prev = 1'b0;

    always #5 clk = ~clk;

    assign readable = (fcnt != 0);

    fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clock_in        (clk),
        .n_reset_in      (n_reset),
        .enable_in       (enable),
        .fifo_readable_in(readable),
        .fifo_rdata_in   (rdata),
        .fifo_read_out   (rd),
        .tx_out          (tx),
        .busy_out        (busy)
    );

    always @(posedge clk) begin
        int inc;
        int dec;
        inc = (wr_en && fcnt < 16) ? 1 : 0;
        dec = (rd && fcnt != 0) ? 1 : 0;
        if (inc == 1) begin
            mem[wp] <= wdata;
            wp      <= wp + 4'd1;
        end
        if (dec == 1) begin
            rdata <= mem[rp];
            rp    <= rp + 4'd1;
        end
        fcnt <= fcnt + inc - dec;
    end

    // Read-strobe monitor: counts pulses and any pulse longer than one cycle.
    always @(posedge clk) begin
        if (rd) begin
            rd_pulses = rd_pulses + 1;
            if (rd_prev) rd_long = rd_long + 1;
        end
        rd_prev = rd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; writes one byte at the following posedge.
    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wdata = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Number of negedges until the start bit is seen (bounded).
    task automatic wait_start(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (tx === 1'b0) break;
        end
    endtask

    // Entered on the first start-bit sample. Checks every cycle of every bit.
    // Optionally writes byte pb into the FIFO at the start of bit push_at.
    task automatic check_frame(input logic [7:0] b, input string tag, input logic par,
                               input int push_at, input logic [7:0] pb);
        logic [N-1:0] w;
        logic [N-1:0] w_exp;
        logic         eb;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i == 0)                    eb = 1'b0;
            else if (i <= 8)               eb = b[i-1];
            else if (i == FRAME_BITS - 1)  eb = 1'b1;
            else                           eb = par;
            for (int k = 0; k < N; k++) begin
                if (!(i == 0 && k == 0)) @(negedge clk);
                w[k] = tx;
                if (i == push_at && k == 0) begin
                    wr_en = 1'b1;
                    wdata = pb;
                end else if (i == push_at && k == 1) begin
                    wr_en = 1'b0;
                end
            end
            w_exp = {N{eb}};
            chk($sformatf("%s_bit%0d", tag, i), w, w_exp);
        end
    endtask

    initial begin
        int c;
        int p0;
        int lows;
        int busys;
        n_reset = 1'b1;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wdata   = 8'h00;
        #2 n_reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd", rd, 1'b0);
        n_reset = 1'b1;
        @(negedge clk);

        // Single byte 0x55
        enable = 1'b1;
        p0 = rd_pulses;
        push(8'h55);
        wait_start(c);
        chk("single_lat", c, 3);
        chk("single_busy", busy, 1'b1);
        check_frame(8'h55, "single", 1'b0, -1, 8'h00);
        @(negedge clk);
        chk("single_busy_end", busy, 1'b0);
        chk("single_tx_end", tx, 1'b1);
        chk("single_pulses", rd_pulses - p0, 1);

        // Back-to-back 0xA3, 0xFF
        p0 = rd_pulses;
        push(8'hA3);
        push(8'hFF);
        wait_start(c);
        check_frame(8'hA3, "b2b1", 1'b0, -1, 8'h00);
        wait_start(c);
        chk("b2b_gap", c - 1, 3);
        check_frame(8'hFF, "b2b2", 1'b0, -1, 8'h00);
        @(negedge clk);
        chk("b2b_busy_end", busy, 1'b0);
        chk("b2b_pulses", rd_pulses - p0, 2);

        // enable gating
        enable = 1'b0;
        push(8'h3C);
        p0 = rd_pulses;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("gate_pulses", rd_pulses - p0, 0);
        chk("gate_tx_low", lows, 0);
        chk("gate_busy", busy, 1'b0);
        enable = 1'b1;
        wait_start(c);
        chk("gate_lat", c, 3);
        enable = 1'b0;
        check_frame(8'h3C, "gate", 1'b0, -1, 8'h00);
        @(negedge clk);
        chk("gate_busy_end", busy, 1'b0);
        push(8'h12);
        p0 = rd_pulses;
        lows = 0;
        busys = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        chk("gate2_pulses", rd_pulses - p0, 0);
        chk("gate2_tx_low", lows, 0);
        chk("gate2_busy", busys, 0);
        enable = 1'b1;
        wait_start(c);
        chk("gate2_lat", c, 3);
        check_frame(8'h12, "gate2", 1'b0, -1, 8'h00);
        @(negedge clk);
        chk("gate2_busy_end", busy, 1'b0);

        // Parity-bearing bytes (parity bit only present in the 8E1 build)
        push(8'h07);
        wait_start(c);
        check_frame(8'h07, "par07", 1'b1, -1, 8'h00);
        @(negedge clk);
        chk("par07_busy_end", busy, 1'b0);

        // Empty / refill while busy
        push(8'h5A);
        wait_start(c);
        check_frame(8'h5A, "rf1", 1'b0, 3, 8'h81);
        @(negedge clk);
        chk("rf_idle_busy", busy, 1'b0);
        chk("rf_idle_rd", rd, 1'b0);
        @(negedge clk);
        chk("rf_rd", rd, 1'b1);
        @(negedge clk);
        chk("rf_load_tx", tx, 1'b1);
        @(negedge clk);
        chk("rf_start", tx, 1'b0);
        check_frame(8'h81, "rf2", 1'b0, -1, 8'h00);
        @(negedge clk);
        chk("rf_busy_end", busy, 1'b0);

        // Reset mid-DATA
        push(8'hC5);
        wait_start(c);
        repeat (9) @(negedge clk);
        chk("rst_pre_tx", tx, 1'b0);
        #2 n_reset = 1'b0;
        #1;
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_rd", rd, 1'b0);
        @(negedge clk);
        n_reset = 1'b1;
        p0 = rd_pulses;
        lows = 0;
        busys = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        chk("post_rst_pulses", rd_pulses - p0, 0);
        chk("post_rst_tx_low", lows, 0);
        chk("post_rst_busy", busys, 0);
        chk("long_pulses", rd_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
